irrigation_zone_scheduler: RTL and testbench
============================================

Name: irrigation_zone_scheduler

Overview:
Multi-zone successor to the single-channel soil-moisture controller. It scans NUM_ZONES soil sensors round-robin through a shared ADC using a req/done handshake. Each zone is watered with hysteresis (on below LOW, off at or above HIGH) and protected by a per-zone watering watchdog that latches a fault. The block sits between the ADC front-end and the pump/valve drivers.

Parameters:
NUM_ZONES, 4, number of sensor/valve zones (2..16)
DATA_W, 10, ADC sample width
DWELL_CYCLES, 64, clock cycles of watering between re-measurements (>=1)
MAX_WATER_CYCLES, 4096, per-visit watering limit before a zone faults (> DWELL_CYCLES)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  single-cycle pulse that begins one scan of all zones; ignored while busy
abort  in  1  synchronous abort; returns to IDLE next cycle
adc_done  in  1  ADC sample valid (one-cycle pulse)
adc_data  in  DATA_W  moisture sample, unsigned, valid with adc_done
low_thresh  in  DATA_W  watering-on threshold
high_thresh  in  DATA_W  watering-off threshold
fault_clr  in  NUM_ZONES  per-zone fault clear, one bit per zone
adc_req  out  1  conversion request, held until adc_done
adc_zone  out  clog2(NUM_ZONES)  mux select for the ADC; equals the current zone
valve_on  out  NUM_ZONES  one-hot valve drive; all zero when not watering
pump_on  out  1  pump drive
busy  out  1  high in every state except IDLE
scan_done  out  1  one-cycle pulse when a scan completes; not asserted on abort
fault  out  NUM_ZONES  sticky per-zone watchdog fault

Behaviour:
- All outputs are registered. On reset: state=IDLE, zone=0, watering=0, all outputs 0, fault=0, counters 0. Reset is honoured in any state, including mid-watering.
- States: IDLE, MEASURE, EVAL, WATER, ADVANCE.
- IDLE: when start=1, set zone=0 and go to MEASURE. adc_req is 1 in the following cycle (latency 1).
- MEASURE: adc_req=1, adc_zone=zone. Hold until adc_done=1; capture adc_data in that cycle, drop adc_req next cycle, then go to EVAL. adc_done outside MEASURE is ignored.
- EVAL (1 cycle):
  - watering=0 and sample<low_thresh: set watering=1, clear wcnt and dcnt, go to WATER.
  - watering=0 otherwise: go to ADVANCE.
  - watering=1 and sample>=high_thresh: set watering=0, go to ADVANCE.
  - watering=1 otherwise: go to WATER (wcnt is not cleared).
- WATER: valve_on[zone]=1, pump_on=1. Each cycle dcnt and wcnt increment.
  - When dcnt reaches DWELL_CYCLES-1: clear dcnt, go to MEASURE.
  - If wcnt reaches MAX_WATER_CYCLES-1, this takes priority over dwell expiry: set fault[zone], watering=0, go to ADVANCE.
- Pump and valve stay on in MEASURE/EVAL while watering=1, so re-measurement does not cycle the pump. They go off the cycle after watering clears.
- ADVANCE (1 cycle): if zone==NUM_ZONES-1, pulse scan_done and go to IDLE. Otherwise zone+1, go to MEASURE. Zones with fault set are skipped at this point: they are not measured and not watered. If the last zone is faulted, the scan ends.
- Skipping zone 0: in IDLE, if fault[0]=1, start goes to ADVANCE with zone=0 instead of MEASURE.
- abort: from any non-IDLE state, next cycle state=IDLE, watering=0, adc_req/valve/pump=0, no scan_done. Faults are kept. abort has priority over start.
- fault_clr[i] clears fault[i] next cycle. If set and clear hit the same bit in the same cycle, set wins.
- Thresholds are sampled live each EVAL. If low_thresh>high_thresh, behaviour follows the comparisons above as written; no error is raised.
- Counters are sized by clog2 of their limits and never wrap: they saturate or clear as stated.

Decomposition:
- Package irrigation_pkg holds the state enum (5 states, 3-bit encoding), the ZONE_W/WCNT_W/DCNT_W width functions, and the default threshold constants.
- One sub-module, zone_watchdog: wcnt/dcnt counters with clear/enable inputs and dwell_expired/limit_reached outputs. Instantiated once and reused across zones.

Test Plan:
- NUM_ZONES=4, low=300, high=600, all samples 700: start -> four req/done handshakes on zones 0..3, no valve/pump activity, scan_done pulses once, busy drops the next cycle.
- Zone 1 samples 200, 400, 650 (DWELL=64): valve_on=4'b0010 and pump_on stay high continuously through 2 dwells and re-measures, turn off after the 650 sample, then the scan proceeds to zone 2. Covers the hysteresis case (400 keeps watering).
- Zone 2 stuck at 100, MAX_WATER=256: after 256 watering cycles fault[2]=1, pump off, zone 3 measured. A second scan skips zone 2 (adc_zone never equals 2). fault_clr[2] re-enables it.
- abort asserted in WATER and in MEASURE: next cycle all outputs 0 and busy=0, no scan_done, faults retained. A start pulse in the same cycle as abort is ignored.
- Asynchronous reset mid-WATER, plus a start pulse while busy, plus adc_done while IDLE: reset clears all outputs immediately, the extra start is ignored, the stray adc_done causes no state change.

Source files
------------

// File: rtl/irrigation_pkg.sv
// ============================================================================
// irrigation_pkg: shared state encoding, counter widths and default thresholds
// Revision: 1.0
// ============================================================================
`default_nettype none

package irrigation_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_MEASURE = 3'd1,
        ST_EVAL    = 3'd2,
        ST_WATER   = 3'd3,
        ST_ADVANCE = 3'd4
    } state_t;

    localparam int DEFAULT_LOW_THRESH  = 300;
    localparam int DEFAULT_HIGH_THRESH = 600;

    // Widths never drop below one bit so degenerate limits still elaborate.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int zone_w(input int num_zones);
        return clog2_min1(num_zones);
    endfunction

    function automatic int wcnt_w(input int max_water_cycles);
        return clog2_min1(max_water_cycles);
    endfunction

    function automatic int dcnt_w(input int dwell_cycles);
        return clog2_min1(dwell_cycles);
    endfunction

endpackage

`default_nettype wire

// File: rtl/irrigation_zone_scheduler_if.sv
// ============================================================================
// irrigation_zone_scheduler_if: shared-ADC request/done handshake bundle
// Revision: 1.0
// ============================================================================
`default_nettype none

interface irrigation_zone_scheduler_if
    import irrigation_pkg::*;
#(
    parameter int NUM_ZONES = 4,
    parameter int DATA_W    = 10
);
    localparam int ZONE_W = zone_w(NUM_ZONES);

    logic              adc_req;
    logic [ZONE_W-1:0] adc_zone;
    logic              adc_done;
    logic [DATA_W-1:0] adc_data;

    modport master (
        output adc_req,
        output adc_zone,
        input  adc_done,
        input  adc_data
    );

    modport slave (
        input  adc_req,
        input  adc_zone,
        output adc_done,
        output adc_data
    );

endinterface

`default_nettype wire

// File: rtl/zone_watchdog.sv
// ============================================================================
// zone_watchdog: dwell and per-visit watering counters for the active zone
// Revision: 1.0
// ============================================================================
`default_nettype none

module zone_watchdog
    import irrigation_pkg::*;
#(
    parameter int DWELL_CYCLES     = 64,
    parameter int MAX_WATER_CYCLES = 4096
)(
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic dwell_expired,
    output logic limit_reached
);

    localparam int DCNT_W = dcnt_w(DWELL_CYCLES);
    localparam int WCNT_W = wcnt_w(MAX_WATER_CYCLES);

    logic [DCNT_W-1:0] dcnt;
    logic [WCNT_W-1:0] wcnt;

    assign dwell_expired = (dcnt == DCNT_W'(DWELL_CYCLES - 1));
    assign limit_reached = (wcnt == WCNT_W'(MAX_WATER_CYCLES - 1));

    // dcnt rolls back to zero on dwell expiry; wcnt saturates at its limit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dcnt <= '0;
            wcnt <= '0;
        end else if (clear) begin
            dcnt <= '0;
            wcnt <= '0;
        end else if (enable) begin
            dcnt <= dwell_expired ? '0 : dcnt + DCNT_W'(1);
            if (!limit_reached) begin
                wcnt <= wcnt + WCNT_W'(1);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/irrigation_zone_scheduler.sv
// ============================================================================
// irrigation_zone_scheduler: round-robin moisture scan with hysteresis watering
// Revision: 1.0
// ============================================================================
`default_nettype none

module irrigation_zone_scheduler
    import irrigation_pkg::*;
#(
    parameter int NUM_ZONES        = 4,
    parameter int DATA_W           = 10,
    parameter int DWELL_CYCLES     = 64,
    parameter int MAX_WATER_CYCLES = 4096
)(
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         abort,
    irrigation_zone_scheduler_if.master  adc,
    input  logic [DATA_W-1:0]            low_thresh,
    input  logic [DATA_W-1:0]            high_thresh,
    input  logic [NUM_ZONES-1:0]         fault_clr,
    output logic [NUM_ZONES-1:0]         valve_on,
    output logic                         pump_on,
    output logic                         busy,
    output logic                         scan_done,
    output logic [NUM_ZONES-1:0]         fault
);

    localparam int                ZONE_W    = zone_w(NUM_ZONES);
    localparam logic [ZONE_W-1:0] LAST_ZONE = ZONE_W'(NUM_ZONES - 1);

    state_t               state;
    logic [ZONE_W-1:0]    zone;
    logic                 watering;
    logic [DATA_W-1:0]    sample;
    logic                 adc_req;

    logic [NUM_ZONES-1:0] zone_onehot;
    logic [NUM_ZONES-1:0] fault_set;
    logic [ZONE_W-1:0]    next_zone;
    logic                 cnt_clear;
    logic                 cnt_enable;
    logic                 dwell_expired;
    logic                 limit_reached;

    assign zone_onehot  = NUM_ZONES'(1) << zone;
    assign next_zone    = zone + ZONE_W'(1);
    assign cnt_enable   = (state == ST_WATER);
    assign cnt_clear    = (state == ST_EVAL) && !watering && (sample < low_thresh);
    assign fault_set    = (cnt_enable && limit_reached) ? zone_onehot : '0;

    assign adc.adc_req  = adc_req;
    assign adc.adc_zone = zone;

    // Only one zone waters at a time, so one counter pair serves them all.
    zone_watchdog #(
        .DWELL_CYCLES     (DWELL_CYCLES),
        .MAX_WATER_CYCLES (MAX_WATER_CYCLES)
    ) u_watchdog (
        .clk           (clk),
        .reset         (reset),
        .clear         (cnt_clear),
        .enable        (cnt_enable),
        .dwell_expired (dwell_expired),
        .limit_reached (limit_reached)
    );

    // A set landing on the same bit as its clear keeps the fault.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fault <= '0;
        end else begin
            fault <= (fault & ~fault_clr) | fault_set;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            zone      <= '0;
            watering  <= 1'b0;
            sample    <= '0;
            adc_req   <= 1'b0;
            valve_on  <= '0;
            pump_on   <= 1'b0;
            busy      <= 1'b0;
            scan_done <= 1'b0;
        end else begin
            scan_done <= 1'b0;
            if (abort && (state != ST_IDLE)) begin
                state    <= ST_IDLE;
                watering <= 1'b0;
                adc_req  <= 1'b0;
                valve_on <= '0;
                pump_on  <= 1'b0;
                busy     <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start && !abort) begin
                            zone <= '0;
                            busy <= 1'b1;
                            if (fault[0]) begin
                                state <= ST_ADVANCE;
                            end else begin
                                state   <= ST_MEASURE;
                                adc_req <= 1'b1;
                            end
                        end
                    end

                    ST_MEASURE: begin
                        if (adc.adc_done) begin
                            sample  <= adc.adc_data;
                            adc_req <= 1'b0;
                            state   <= ST_EVAL;
                        end
                    end

                    // Pump and valve are left untouched while watering continues,
                    // so a re-measurement never cycles the pump.
                    ST_EVAL: begin
                        if (!watering) begin
                            if (sample < low_thresh) begin
                                watering <= 1'b1;
                                valve_on <= zone_onehot;
                                pump_on  <= 1'b1;
                                state    <= ST_WATER;
                            end else begin
                                state <= ST_ADVANCE;
                            end
                        end else if (sample >= high_thresh) begin
                            watering <= 1'b0;
                            valve_on <= '0;
                            pump_on  <= 1'b0;
                            state    <= ST_ADVANCE;
                        end else begin
                            state <= ST_WATER;
                        end
                    end

                    ST_WATER: begin
                        if (limit_reached) begin
                            watering <= 1'b0;
                            valve_on <= '0;
                            pump_on  <= 1'b0;
                            state    <= ST_ADVANCE;
                        end else if (dwell_expired) begin
                            adc_req <= 1'b1;
                            state   <= ST_MEASURE;
                        end
                    end

                    // Faulted zones are stepped over one per cycle without a measurement.
                    ST_ADVANCE: begin
                        if (zone == LAST_ZONE) begin
                            scan_done <= 1'b1;
                            busy      <= 1'b0;
                            state     <= ST_IDLE;
                        end else begin
                            zone <= next_zone;
                            if (!fault[next_zone]) begin
                                adc_req <= 1'b1;
                                state   <= ST_MEASURE;
                            end
                        end
                    end

                    default: begin
                        state    <= ST_IDLE;
                        watering <= 1'b0;
                        adc_req  <= 1'b0;
                        valve_on <= '0;
                        pump_on  <= 1'b0;
                        busy     <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_irrigation_zone_scheduler.sv
// ============================================================================
// tb_irrigation_zone_scheduler: directed checks with a scripted ADC responder
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_irrigation_zone_scheduler;
    import irrigation_pkg::*;

    logic       clk;
    logic       reset;
    logic       start;
    logic       abort;
    logic [9:0] low_thresh;
    logic [9:0] high_thresh;
    logic [3:0] fault_clr;
    logic [3:0] valve_on;
    logic       pump_on;
    logic       busy;
    logic       scan_done;
    logic [3:0] fault;

    irrigation_zone_scheduler_if #(.NUM_ZONES(4), .DATA_W(10)) adc_bus ();

    irrigation_zone_scheduler #(
        .NUM_ZONES        (4),
        .DATA_W           (10),
        .DWELL_CYCLES     (64),
        .MAX_WATER_CYCLES (256)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .abort       (abort),
        .adc         (adc_bus),
        .low_thresh  (low_thresh),
        .high_thresh (high_thresh),
        .fault_clr   (fault_clr),
        .valve_on    (valve_on),
        .pump_on     (pump_on),
        .busy        (busy),
        .scan_done   (scan_done),
        .fault       (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    // Scripted ADC samples; anything beyond the script reads as dry soil (700).
    logic [9:0] samp [64];
    int         wr_idx = 0;
    int         rd_idx = 0;
    bit         resp_en = 1'b1;
    int         stray_cnt = 0;
    int         stray_seen = 0;
    int         wait_cnt = 0;
    logic [1:0] zone_log [$];

    int sd_cnt      = 0;
    int pump_cyc    = 0;
    int pump_rises  = 0;
    int valve_cyc [4] = '{0, 0, 0, 0};
    bit pump_prev   = 1'b0;

    initial begin
        adc_bus.adc_done = 1'b0;
        adc_bus.adc_data = '0;
        forever begin
            @(negedge clk);
            adc_bus.adc_done = 1'b0;
            if (stray_cnt != stray_seen) begin
                stray_seen       = stray_cnt;
                adc_bus.adc_done = 1'b1;
                adc_bus.adc_data = 10'd0;
            end else if (adc_bus.adc_req && resp_en) begin
                if (wait_cnt == 1) begin
                    adc_bus.adc_done = 1'b1;
                    if (rd_idx < wr_idx) begin
                        adc_bus.adc_data = samp[rd_idx];
                        rd_idx++;
                    end else begin
                        adc_bus.adc_data = 10'd700;
                    end
                    zone_log.push_back(adc_bus.adc_zone);
                    wait_cnt = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (scan_done) sd_cnt++;
            if (pump_on) pump_cyc++;
            if (pump_on && !pump_prev) pump_rises++;
            pump_prev = pump_on;
            for (int i = 0; i < 4; i++) begin
                if (valve_on[i]) valve_cyc[i]++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: observed no finish, expected finish");
        $fatal(1, "simulation time limit reached");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_samp(input logic [9:0] v);
        samp[wr_idx] = v;
        wr_idx++;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (busy && (n < budget)) begin
            @(negedge clk);
            n++;
        end
        chk(tag, {31'd0, busy}, 32'd0);
        step(2);
    endtask

    task automatic wait_pump(input string tag, input int budget);
        int n = 0;
        while (!pump_on && (n < budget)) begin
            @(negedge clk);
            n++;
        end
        chk(tag, {31'd0, pump_on}, 32'd1);
    endtask

    function automatic logic [31:0] pack_log(input int base);
        logic [31:0] p = '0;
        for (int i = base; i < zone_log.size(); i++) begin
            p = (p << 2) | {30'd0, zone_log[i]};
        end
        return p;
    endfunction

    int sd_b, pc_b, pr_b, log_b, v1_b, v2_b;

    task automatic snap();
        sd_b  = sd_cnt;
        pc_b  = pump_cyc;
        pr_b  = pump_rises;
        log_b = zone_log.size();
        v1_b  = valve_cyc[1];
        v2_b  = valve_cyc[2];
    endtask

    initial begin
        reset       = 1'b1;
        start       = 1'b0;
        abort       = 1'b0;
        fault_clr   = 4'd0;
        low_thresh  = 10'(DEFAULT_LOW_THRESH);
        high_thresh = 10'(DEFAULT_HIGH_THRESH);

        step(2);
        chk("rst_busy",  {31'd0, busy}, 32'd0);
        chk("rst_req",   {31'd0, adc_bus.adc_req}, 32'd0);
        chk("rst_zone",  {30'd0, adc_bus.adc_zone}, 32'd0);
        chk("rst_outs",  {26'd0, valve_on, pump_on, scan_done}, 32'd0);
        chk("rst_fault", {28'd0, fault}, 32'd0);
        reset = 1'b0;
        step(2);

        // Dry soil everywhere: four handshakes, no watering.
        snap();
        pulse_start();
        chk("s1_req_latency", {31'd0, adc_bus.adc_req}, 32'd1);
        chk("s1_busy",        {31'd0, busy}, 32'd1);
        wait_idle("s1_timeout", 300);
        chk("s1_scan_done_cnt", sd_cnt - sd_b, 32'd1);
        chk("s1_zone_order",    pack_log(log_b), 32'h1B);
        chk("s1_log_len",       zone_log.size() - log_b, 32'd4);
        chk("s1_pump_cycles",   pump_cyc - pc_b, 32'd0);
        chk("s1_scan_done_low", {31'd0, scan_done}, 32'd0);

        // Zone 1 reads 200 then 400 (inside hysteresis band) then 650.
        snap();
        push_samp(10'd700);
        push_samp(10'd200);
        push_samp(10'd400);
        push_samp(10'd650);
        push_samp(10'd700);
        push_samp(10'd700);
        pulse_start();
        wait_pump("s2_pump_on", 50);
        chk("s2_valve", {28'd0, valve_on}, 32'h2);
        wait_idle("s2_timeout", 1000);
        chk("s2_zone_order",  pack_log(log_b), 32'h15B);
        chk("s2_pump_cycles", pump_cyc - pc_b, 32'd134);
        chk("s2_valve1_cyc",  valve_cyc[1] - v1_b, 32'd134);
        chk("s2_pump_rises",  pump_rises - pr_b, 32'd1);
        chk("s2_scan_done",   sd_cnt - sd_b, 32'd1);

        // Zone 2 never dries out enough: watchdog trips after 256 watering cycles.
        snap();
        push_samp(10'd700);
        push_samp(10'd700);
        repeat (4) push_samp(10'd100);
        push_samp(10'd700);
        pulse_start();
        wait_idle("s3_timeout", 2000);
        chk("s3_fault",        {28'd0, fault}, 32'h4);
        chk("s3_pump_off",     {31'd0, pump_on}, 32'd0);
        chk("s3_zone_order",   pack_log(log_b), 32'h6AB);
        chk("s3_pump_cycles",  pump_cyc - pc_b, 32'd265);
        chk("s3_valve2_cyc",   valve_cyc[2] - v2_b, 32'd265);
        chk("s3_scan_done",    sd_cnt - sd_b, 32'd1);

        // Faulted zone 2 is skipped on the next scan.
        snap();
        pulse_start();
        wait_idle("s4_timeout", 300);
        chk("s4_zone_order", pack_log(log_b), 32'h07);
        chk("s4_log_len",    zone_log.size() - log_b, 32'd3);
        chk("s4_fault_kept", {28'd0, fault}, 32'h4);

        // Abort while watering zone 0.
        snap();
        push_samp(10'd100);
        pulse_start();
        wait_pump("s5_pump_on", 50);
        step(5);
        chk("s5_valve", {28'd0, valve_on}, 32'h1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("s5_abort_outs",  {26'd0, valve_on, pump_on, scan_done}, 32'd0);
        chk("s5_abort_req",   {31'd0, adc_bus.adc_req}, 32'd0);
        chk("s5_abort_busy",  {31'd0, busy}, 32'd0);
        step(2);
        chk("s5_no_scan_done", sd_cnt - sd_b, 32'd0);
        chk("s5_fault_kept",   {28'd0, fault}, 32'h4);

        // Abort while waiting in MEASURE, with a start pulse in the same cycle.
        resp_en = 1'b0;
        pulse_start();
        step(3);
        chk("s6_req_held",  {31'd0, adc_bus.adc_req}, 32'd1);
        abort = 1'b1;
        start = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        start = 1'b0;
        chk("s6_abort_req",  {31'd0, adc_bus.adc_req}, 32'd0);
        chk("s6_abort_busy", {31'd0, busy}, 32'd0);
        step(1);
        chk("s6_start_ignored", {31'd0, busy}, 32'd0);
        resp_en = 1'b1;

        // Abort outranks start even from IDLE.
        abort = 1'b1;
        start = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        start = 1'b0;
        chk("s7_idle_abort_start", {30'd0, busy, adc_bus.adc_req}, 32'd0);
        chk("s7_no_scan_done",     sd_cnt - sd_b, 32'd0);

        // Clearing fault[2] brings zone 2 back into the rotation.
        fault_clr = 4'b0100;
        @(negedge clk);
        fault_clr = 4'd0;
        chk("s8_fault_cleared", {28'd0, fault}, 32'h0);
        snap();
        pulse_start();
        wait_idle("s8_timeout", 300);
        chk("s8_zone_order", pack_log(log_b), 32'h1B);

        // Asynchronous reset mid-watering, after an ignored start while busy.
        push_samp(10'd100);
        pulse_start();
        wait_pump("s9_pump_on", 50);
        step(3);
        pulse_start();
        chk("s9_busy_start_ignored", {26'd0, valve_on, adc_bus.adc_zone}, {26'd0, 4'b0001, 2'd0});
        chk("s9_still_busy",         {31'd0, busy}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("s9_async_outs", {26'd0, valve_on, pump_on, busy}, 32'd0);
        chk("s9_async_req",  {31'd0, adc_bus.adc_req}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        step(1);

        // A stray adc_done in IDLE must not start anything.
        stray_cnt++;
        step(3);
        chk("s10_stray_done", {30'd0, busy, adc_bus.adc_req}, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
